// File: rtl/dmem_wb_bridge_if.sv
// Signal bundle between the hart data-memory port, dmem_wb_bridge and its Wishbone B4 classic slave.
// The master modport is the bridge's view; the slave modport is the surrounding environment's view.
interface dmem_wb_bridge_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;
  logic        dmem_fault;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [29:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    input  dmem_req, dmem_addr, dmem_wmask, dmem_wdata, wb_dat_r, wb_ack, wb_err,
    output dmem_rdata, dmem_stall, dmem_fault, wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w
  );

  modport slave (
    output dmem_req, dmem_addr, dmem_wmask, dmem_wdata, wb_dat_r, wb_ack, wb_err,
    input  dmem_rdata, dmem_stall, dmem_fault, wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w
  );
endinterface

// File: rtl/dmem_wb_bridge.sv
// Hart dmem request/stall port to single-master Wishbone B4 classic bridge, one bus cycle per access.
// Define DMEM_BRIDGE_TIMEOUT_EN to abort a cycle with a fault after TIMEOUT_CYCLES unterminated BUS cycles.
module dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_wb_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_w_q, dat_w_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        expire_s;
  logic        is_store_s;
  logic        unused_s;

  assign is_store_s = (bus.dmem_wmask != 4'b0000);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The current BUS cycle is the last one allowed once TIMEOUT_CYCLES-1 cycles have already elapsed.
  assign expire_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));
  assign unused_s = ^bus.dmem_addr[1:0];

  // Watchdog next state: counts BUS cycles, held at zero elsewhere so it is clear on BUS entry
  always_comb begin
    if (state_q == BUS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expire_s = 1'b0;
  assign unused_s = ^{bus.dmem_addr[1:0], TIMEOUT_CYCLES};
`endif

  // Next-state, bus-latch and response capture
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_w_d = dat_w_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dmem_req) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = is_store_s;
          adr_d   = bus.dmem_addr[31:2];
          dat_w_d = bus.dmem_wdata;
          if (is_store_s) begin
            sel_d = bus.dmem_wmask;
          end else begin
            sel_d = 4'b1111;
          end
        end else begin
          cyc_d = 1'b0;
        end
      end
      BUS: begin
        // err outranks ack; ack outranks a watchdog expiry in the same cycle
        if (bus.wb_err) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          rdata_d = ERR_RDATA;
          fault_d = 1'b1;
        end else if (bus.wb_ack) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          if (we_q) begin
            rdata_d = rdata_q;
          end else begin
            rdata_d = bus.wb_dat_r;
          end
        end else if (expire_s) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          rdata_d = ERR_RDATA;
          fault_d = 1'b1;
        end else begin
          cyc_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 30'h0;
      sel_q   <= 4'h0;
      dat_w_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_w_q <= dat_w_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign bus.wb_cyc     = cyc_q;
  assign bus.wb_stb     = cyc_q;
  assign bus.wb_we      = we_q;
  assign bus.wb_adr     = adr_q;
  assign bus.wb_sel     = sel_q;
  assign bus.wb_dat_w   = dat_w_q;
  assign bus.dmem_rdata = rdata_q;
  assign bus.dmem_fault = fault_q;
  // Gated by rst_n so the hart sees the stall release immediately on an asynchronous reset.
  assign bus.dmem_stall = rst_n & bus.dmem_req & (state_q != RESP);

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Randomized self-checking bench for dmem_wb_bridge: each access's expected trace is derived from
// its wait-state count and termination kind; a few literal expectations pin the model.
module tb_dmem_wb_bridge;
  localparam int TO_CYC = 4;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int MAX_WAIT = TO_CYC - 1;
`else
  localparam int MAX_WAIT = 6;
`endif
  localparam logic [31:0] ERR_VAL = 32'h0000_0000;
  localparam int T_ACK  = 0;
  localparam int T_ERR  = 1;
  localparam int T_BOTH = 2;
  localparam int T_TO   = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  dmem_wb_bridge_if bus ();

  dmem_wb_bridge #(
    .TIMEOUT_CYCLES(TO_CYC),
    .ERR_RDATA     (ERR_VAL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model: what the outputs must be in the current cycle
  logic        exp_stall, exp_cyc, exp_resp, exp_fault, exp_we;
  logic [29:0] exp_adr;
  logic [3:0]  exp_sel;
  logic [31:0] exp_datw, exp_rdata, last_rdata;

  // observations of the DUT, used only by the literal pins
  int          cyc_no, cyc_total, stall_total, fault_total, rise_cyc, resp_cyc;
  logic        prev_cyc, obs_we, obs_fault;
  logic [29:0] obs_adr;
  logic [3:0]  obs_sel;
  logic [31:0] obs_datw, obs_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_no, act, exp);
    end
  endtask

  task automatic compare_cycle();
    chk("stall", 32'(bus.dmem_stall), 32'(exp_stall));
    chk("cyc",   32'(bus.wb_cyc),     32'(exp_cyc));
    chk("stb",   32'(bus.wb_stb),     32'(exp_cyc));
    chk("adr",   32'(bus.wb_adr),     32'(exp_adr));
    chk("sel",   32'(bus.wb_sel),     32'(exp_sel));
    chk("we",    32'(bus.wb_we),      32'(exp_we));
    chk("dat_w", bus.wb_dat_w,        exp_datw);
    if (exp_resp) begin
      chk("rdata", bus.dmem_rdata,       exp_rdata);
      chk("fault", 32'(bus.dmem_fault),  32'(exp_fault));
    end else begin
      chk("fault_quiet", 32'(bus.dmem_fault), 32'd0);
    end
    if (bus.wb_cyc) begin
      cyc_total++;
      obs_adr  = bus.wb_adr;
      obs_sel  = bus.wb_sel;
      obs_we   = bus.wb_we;
      obs_datw = bus.wb_dat_w;
      if (!prev_cyc) rise_cyc = cyc_no;
    end
    if (bus.dmem_stall) stall_total++;
    if (bus.dmem_fault) fault_total++;
    if (bus.dmem_req && !bus.dmem_stall) begin
      obs_rdata = bus.dmem_rdata;
      obs_fault = bus.dmem_fault;
      resp_cyc  = cyc_no;
    end
    prev_cyc = bus.wb_cyc;
    cyc_no++;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_stall  = 1'b0;
    exp_cyc    = 1'b0;
    exp_resp   = 1'b0;
    exp_fault  = 1'b0;
    exp_we     = 1'b0;
    exp_adr    = 30'h0;
    exp_sel    = 4'h0;
    exp_datw   = 32'h0;
    exp_rdata  = 32'h0;
    last_rdata = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dmem_req   = 1'b0;
      bus.dmem_addr  = $urandom;
      bus.dmem_wmask = 4'($urandom);
      bus.dmem_wdata = $urandom;
      bus.wb_ack     = 1'($urandom);
      bus.wb_err     = 1'($urandom);
      bus.wb_dat_r   = $urandom;
      exp_stall = 1'b0;
      exp_cyc   = 1'b0;
      exp_resp  = 1'b0;
      next_cycle();
    end
  endtask

  // One hart access: IDLE cycle, waits+1 BUS cycles (terminated in the last), one RESP cycle.
  task automatic access(input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd,
                        input int waits, input int term, input logic [31:0] sdata);
    int          len, tcyc;
    logic [31:0] resp;
    tcyc = waits + 1;
    len  = waits + 3;
    if (term == T_ACK) resp = (wm == 4'b0000) ? sdata : last_rdata;
    else               resp = ERR_VAL;
    for (int k = 0; k < len; k++) begin
      bus.dmem_req   = 1'b1;
      bus.dmem_addr  = addr;
      bus.dmem_wmask = wm;
      bus.dmem_wdata = wd;
      if (k == tcyc) begin
        bus.wb_ack   = (term == T_ACK || term == T_BOTH);
        bus.wb_err   = (term == T_ERR || term == T_BOTH);
        bus.wb_dat_r = sdata;
      end else if (k >= 1 && k < tcyc) begin
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_dat_r = $urandom;
      end else begin
        bus.wb_ack   = 1'($urandom);
        bus.wb_err   = 1'($urandom);
        bus.wb_dat_r = $urandom;
      end
      exp_stall = (k != len - 1);
      exp_cyc   = (k >= 1 && k <= tcyc);
      exp_resp  = (k == len - 1);
      exp_rdata = resp;
      exp_fault = (term == T_ERR || term == T_BOTH || term == T_TO);
      if (k == 1) begin
        exp_adr  = addr[31:2];
        exp_sel  = (wm == 4'b0000) ? 4'b1111 : wm;
        exp_we   = (wm != 4'b0000);
        exp_datw = wd;
      end
      next_cycle();
    end
    last_rdata = resp;
  endtask

  // A load whose slave never answers, observed for ncyc cycles.
  task automatic hold_noack(input logic [31:0] addr, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      bus.dmem_req   = 1'b1;
      bus.dmem_addr  = addr;
      bus.dmem_wmask = 4'b0000;
      bus.dmem_wdata = 32'h0;
      bus.wb_ack     = 1'b0;
      bus.wb_err     = 1'b0;
      bus.wb_dat_r   = $urandom;
      exp_stall = 1'b1;
      exp_cyc   = (k >= 1);
      exp_resp  = 1'b0;
      if (k == 1) begin
        exp_adr  = addr[31:2];
        exp_sel  = 4'b1111;
        exp_we   = 1'b0;
        exp_datw = 32'h0;
      end
      next_cycle();
    end
  endtask

  initial begin
    int          s_cyc, s_stall, s_fault, r1, waits, term, r;
    logic [3:0]  wm;

    cyc_no = 0; cyc_total = 0; stall_total = 0; fault_total = 0;
    rise_cyc = 0; resp_cyc = 0; prev_cyc = 1'b0;
    obs_we = 1'b0; obs_fault = 1'b0; obs_adr = 30'h0; obs_sel = 4'h0;
    obs_datw = 32'h0; obs_rdata = 32'h0;
    rst_n = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_addr = 32'h0; bus.dmem_wmask = 4'h0; bus.dmem_wdata = 32'h0;
    bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_r = 32'h0;
    model_reset();
    next_cycle();
    next_cycle();
    chk("reset_rdata", bus.dmem_rdata, 32'h0);
    chk("reset_fault", 32'(bus.dmem_fault), 32'd0);
    chk("reset_cyc", 32'(bus.wb_cyc), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: zero-wait load
    s_stall = stall_total;
    access(32'h0000_1004, 4'b0000, 32'h0, 0, T_ACK, 32'hDEAD_BEEF);
    chk("t1_adr", 32'(obs_adr), 32'h0000_0401);
    chk("t1_sel", 32'(obs_sel), 32'h0000_000F);
    chk("t1_we", 32'(obs_we), 32'd0);
    chk("t1_stall_cycles", 32'(stall_total - s_stall), 32'd2);
    chk("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("t1_fault", 32'(obs_fault), 32'd0);
    idle(1);

    // 2: byte store, 3 wait states
    s_stall = stall_total;
    s_cyc   = cyc_total;
    access(32'h0000_2003, 4'b1000, 32'hAB00_0000, 3, T_ACK, 32'h1357_9BDF);
    chk("t2_we", 32'(obs_we), 32'd1);
    chk("t2_sel", 32'(obs_sel), 32'h0000_0008);
    chk("t2_adr", 32'(obs_adr), 32'h0000_0800);
    chk("t2_datw", obs_datw, 32'hAB00_0000);
    chk("t2_cyc_cycles", 32'(cyc_total - s_cyc), 32'd4);
    chk("t2_stall_cycles", 32'(stall_total - s_stall), 32'd5);
    idle(1);

    // 3: ack and err together
    s_fault = fault_total;
    access(32'h0000_3000, 4'b0000, 32'h0, 0, T_BOTH, 32'h1234_5678);
    chk("t3_rdata", obs_rdata, 32'h0000_0000);
    chk("t3_fault", 32'(obs_fault), 32'd1);
    idle(1);
    chk("t3_fault_width", 32'(fault_total - s_fault), 32'd1);

    // 4: back-to-back loads with req held
    access(32'h0000_4000, 4'b0000, 32'h0, 0, T_ACK, 32'h1111_1111);
    chk("t4_rdata_a", obs_rdata, 32'h1111_1111);
    r1 = resp_cyc;
    access(32'h0000_4004, 4'b0000, 32'h0, 1, T_ACK, 32'h2222_2222);
    chk("t4_rdata_b", obs_rdata, 32'h2222_2222);
    chk("t4_gap", 32'(rise_cyc - r1), 32'd2);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      wm    = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom);
      waits = int'($urandom_range(MAX_WAIT, 0));
      r     = int'($urandom_range(9, 0));
      term  = (r == 7) ? T_ERR : ((r == 8) ? T_BOTH : T_ACK);
      access($urandom, wm, $urandom, waits, term, $urandom);
      idle(int'($urandom_range(2, 0)));
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // 6: watchdog abort, and an ack on the expiry cycle winning
    s_cyc = cyc_total;
    access(32'h0000_5000, 4'b0000, 32'h0, TO_CYC - 1, T_TO, 32'hCAFE_F00D);
    chk("t6_cyc_cycles", 32'(cyc_total - s_cyc), 32'd4);
    chk("t6_fault", 32'(obs_fault), 32'd1);
    chk("t6_rdata", obs_rdata, 32'h0000_0000);
    access(32'h0000_5004, 4'b0000, 32'h0, TO_CYC - 1, T_ACK, 32'h5A5A_A5A5);
    chk("t6_ack_wins_fault", 32'(obs_fault), 32'd0);
    chk("t6_ack_wins_rdata", obs_rdata, 32'h5A5A_A5A5);
    idle(1);
    hold_noack(32'h0000_6000, 3);
`else
    // 6: no watchdog, the bridge waits indefinitely
    s_stall = stall_total;
    hold_noack(32'h0000_6000, 121);
    chk("t6_hang_stall", 32'(stall_total - s_stall), 32'd121);
`endif

    // 5: asynchronous reset while in BUS
    rst_n = 1'b0;
    #1;
    chk("t5_cyc_async", 32'(bus.wb_cyc), 32'd0);
    chk("t5_stb_async", 32'(bus.wb_stb), 32'd0);
    chk("t5_stall_async", 32'(bus.dmem_stall), 32'd0);
    model_reset();
    bus.dmem_req = 1'b0;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    idle(1);
    access(32'h0000_7008, 4'b0000, 32'h0, 2, T_ACK, 32'h0BAD_F00D);
    chk("t5_after_rdata", obs_rdata, 32'h0BAD_F00D);
    chk("t5_after_adr", 32'(obs_adr), 32'h0000_1C02);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
